// File: rtl/sys_ctrl_sched.sv
// System controller: decodes UART command bytes into register-file writes and
// reads and ALU operations, then returns results to the TX FIFO. One byte is
// accepted per RX_D_VLD pulse. All outputs are registered.
//
// Strobe semantics: RX_D_VLD, RF_RD_VLD and ALU_OUT_VLD are one-cycle "valid"
// pulses. They are consumed only in the state that waits for them and are
// dropped in every other state. FIFO_FULL is the inverse of "ready" for TX.
// A byte moves on the cycle when TX_D_VLD is high, and TX_D_VLD is only raised
// when FIFO_FULL was low at the deciding edge. RF_WR_EN, RF_RD_EN, ALU_EN and
// TX_D_VLD are one-cycle pulses. Their address, data and function buses hold
// their last value while the pulse is low.
module sys_ctrl_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                      REF_CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
  input  logic                      RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
  input  logic                      RF_RD_VLD,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  input  logic                      FIFO_FULL,
  output logic                      RF_WR_EN,
  output logic                      RF_RD_EN,
  output logic [ADDR_WIDTH-1:0]     RF_ADDR,
  output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
  output logic                      ALU_EN,
  output logic [3:0]                ALU_FUN,
  output logic                      CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]     TX_P_DATA,
  output logic                      TX_D_VLD,
  output logic [3:0]                dbg_state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    TX_RD    = 4'd5,
    OPA      = 4'd6,
    OPB      = 4'd7,
    FUN      = 4'd8,
    ALU_WAIT = 4'd9,
    TX_LSB   = 4'd10,
    TX_MSB   = 4'd11
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
  logic [2*DATA_WIDTH-1:0]   alu_res_q, alu_res_d;

  logic                      wr_en_d, rd_en_d, alu_en_d, tx_vld_d, gate_d;
  logic [ADDR_WIDTH-1:0]     rf_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_d, tx_data_d;
  logic [3:0]                alu_fun_d;

  // A TX push waits for FIFO space. It also waits out the cycle of a previous
  // push, so that back-to-back result bytes never produce two adjacent strobes.
  logic tx_ok;
  assign tx_ok = !FIFO_FULL && !TX_D_VLD;

  assign dbg_state = state_q;

  // Next-state and next-output decode; strobes default low, buses hold.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_data_d = rd_data_q;
    alu_res_d = alu_res_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    tx_vld_d  = 1'b0;
    gate_d    = CLK_GATE_EN;
    rf_addr_d = RF_ADDR;
    wr_data_d = RF_WR_DATA;
    alu_fun_d = ALU_FUN;
    tx_data_d = TX_P_DATA;
    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR)       state_d = WR_ADDR;
          else if (RX_P_DATA == CMD_RD)  state_d = RD_ADDR;
          else if (RX_P_DATA == CMD_ALU) state_d = OPA;
          else if (RX_P_DATA == CMD_FUN) state_d = FUN;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          wr_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          rf_addr_d = wr_addr_q;
          wr_data_d = RX_P_DATA;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          rd_en_d   = 1'b1;
          rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RF_RD_VLD) begin
          rd_data_d = RF_RD_DATA;
          state_d   = TX_RD;
        end
      end
      TX_RD: begin
        if (tx_ok) begin
          tx_vld_d  = 1'b1;
          tx_data_d = rd_data_q;
          state_d   = IDLE;
        end
      end
      OPA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          rf_addr_d = '0;
          wr_data_d = RX_P_DATA;
          state_d   = OPB;
        end
      end
      OPB: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          rf_addr_d = ADDR_WIDTH'(1);
          wr_data_d = RX_P_DATA;
          state_d   = FUN;
        end
      end
      FUN: begin
        if (RX_D_VLD) begin
          alu_en_d  = 1'b1;
          alu_fun_d = RX_P_DATA[3:0];
          gate_d    = 1'b1;
          state_d   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          alu_res_d = ALU_OUT;
          gate_d    = 1'b0;
          state_d   = TX_LSB;
        end
      end
      TX_LSB: begin
        if (tx_ok) begin
          tx_vld_d  = 1'b1;
          tx_data_d = alu_res_q[DATA_WIDTH-1:0];
          state_d   = TX_MSB;
        end
      end
      TX_MSB: begin
        if (tx_ok) begin
          tx_vld_d  = 1'b1;
          tx_data_d = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched operands/results and registered outputs; reset abandons any command.
  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      rd_data_q   <= '0;
      alu_res_q   <= '0;
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      ALU_EN      <= 1'b0;
      TX_D_VLD    <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      RF_ADDR     <= '0;
      RF_WR_DATA  <= '0;
      ALU_FUN     <= '0;
      TX_P_DATA   <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_data_q   <= rd_data_d;
      alu_res_q   <= alu_res_d;
      RF_WR_EN    <= wr_en_d;
      RF_RD_EN    <= rd_en_d;
      ALU_EN      <= alu_en_d;
      TX_D_VLD    <= tx_vld_d;
      CLK_GATE_EN <= gate_d;
      RF_ADDR     <= rf_addr_d;
      RF_WR_DATA  <= wr_data_d;
      ALU_FUN     <= alu_fun_d;
      TX_P_DATA   <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_sys_ctrl_sched.sv
// Bench for sys_ctrl_sched: a command-level model turns sent bytes into
// expected strobe transactions; register-file and ALU responders emulate the
// surrounding blocks; one negedge process checks every cycle.
module tb_sys_ctrl_sched;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [7:0]  rx_p_data = '0;
  logic        rx_d_vld = 1'b0;
  logic [7:0]  rf_rd_data = '0;
  logic        rf_rd_vld = 1'b0;
  logic [15:0] alu_out = '0;
  logic        alu_out_vld = 1'b0;
  logic        fifo_full = 1'b0;
  logic        rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_d_vld;
  logic [3:0]  rf_addr, alu_fun, dbg_state;
  logic [7:0]  rf_wr_data, tx_p_data;

  sys_ctrl_sched #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .REF_CLK(clk), .RST(rst),
    .RX_P_DATA(rx_p_data), .RX_D_VLD(rx_d_vld),
    .RF_RD_DATA(rf_rd_data), .RF_RD_VLD(rf_rd_vld),
    .ALU_OUT(alu_out), .ALU_OUT_VLD(alu_out_vld),
    .FIFO_FULL(fifo_full),
    .RF_WR_EN(rf_wr_en), .RF_RD_EN(rf_rd_en),
    .RF_ADDR(rf_addr), .RF_WR_DATA(rf_wr_data),
    .ALU_EN(alu_en), .ALU_FUN(alu_fun),
    .CLK_GATE_EN(clk_gate_en),
    .TX_P_DATA(tx_p_data), .TX_D_VLD(tx_d_vld),
    .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- command-level model ----------------
  logic [7:0]  cmd_q[$];
  logic [11:0] exp_wr_q[$];   // {addr, data}
  logic [3:0]  exp_rd_q[$];
  logic [3:0]  exp_alu_q[$];
  logic [7:0]  exp_q[$];      // expected TX bytes, in order
  logic [7:0]  tx_log[$];
  logic [7:0]  m_mem[16];
  bit          m_busy = 0;    // a read/ALU result is still owed: new bytes are dropped
  logic [15:0] alu_ret = '0;
  int          alu_delay = 3;

  function automatic void expect_alu(input logic [7:0] f);
    exp_alu_q.push_back(f[3:0]);
    exp_q.push_back(alu_ret[7:0]);
    exp_q.push_back(alu_ret[15:8]);
    m_busy = 1;
    cmd_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] op, a;
    if (m_busy) return;
    if (cmd_q.size() == 0 && !(b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD})) return;
    cmd_q.push_back(b);
    op = cmd_q[0];
    case (op)
      8'hAA: if (cmd_q.size() == 3) begin
        a = cmd_q[1];
        exp_wr_q.push_back({a[3:0], b});
        m_mem[a[3:0]] = b;
        cmd_q.delete();
      end
      8'hBB: if (cmd_q.size() == 2) begin
        exp_rd_q.push_back(b[3:0]);
        exp_q.push_back(m_mem[b[3:0]]);
        m_busy = 1;
        cmd_q.delete();
      end
      8'hCC: begin
        if (cmd_q.size() == 2) begin exp_wr_q.push_back({4'h0, b}); m_mem[0] = b; end
        if (cmd_q.size() == 3) begin exp_wr_q.push_back({4'h1, b}); m_mem[1] = b; end
        if (cmd_q.size() == 4) expect_alu(b);
      end
      8'hDD: if (cmd_q.size() == 2) expect_alu(b);
      default: cmd_q.delete();
    endcase
  endfunction

  function automatic void model_reset();
    cmd_q.delete(); exp_wr_q.delete(); exp_rd_q.delete();
    exp_alu_q.delete(); exp_q.delete();
    m_busy = 0;
  endfunction

  // ---------------- register file and ALU responders ----------------
  logic [7:0] rf_mem[16];
  int rd_cnt = 0, alu_cnt = 0;
  logic [3:0] rd_addr_l;

  initial begin
    for (int i = 0; i < 16; i++) begin rf_mem[i] = '0; m_mem[i] = '0; end
    forever begin
      @(posedge clk); #1;
      rf_rd_vld   = 1'b0;
      alu_out_vld = 1'b0;
      if (rst) begin
        rd_cnt = 0; alu_cnt = 0;
      end else begin
        if (rf_wr_en) rf_mem[rf_addr] = rf_wr_data;
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin rf_rd_vld = 1'b1; rf_rd_data = rf_mem[rd_addr_l]; end
        end
        if (rf_rd_en) begin rd_cnt = 2; rd_addr_l = rf_addr; end
        if (alu_cnt > 0) begin
          alu_cnt--;
          if (alu_cnt == 0) begin alu_out_vld = 1'b1; alu_out = alu_ret; end
        end
        if (alu_en) alu_cnt = alu_delay;
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  int n_wr = 0, n_rd = 0, n_alu = 0, n_tx = 0;
  bit gate_open = 0, last_full = 0;
  logic p_wr = 0, p_rd = 0, p_alu = 0, p_tx = 0;
  logic [3:0] p_addr = '0, p_fun = '0;
  logic [7:0] p_wdata = '0, p_txd = '0;

  always @(negedge clk) begin
    int n_hi;
    if (rst) begin
      gate_open = 0;
    end else begin
      n_hi = int'(rf_wr_en) + int'(rf_rd_en) + int'(alu_en) + int'(tx_d_vld);
      if (n_hi > 0) begin
        check("strobe_exclusive", (n_hi <= 1), 1);
        check("strobe_no_repeat", (rf_wr_en && p_wr) || (rf_rd_en && p_rd) ||
                                  (alu_en && p_alu) || (tx_d_vld && p_tx), 0);
      end
      if (rf_wr_en) begin
        n_wr++;
        if (exp_wr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rf_wr: strobe with addr=0x%0h data=0x%0h, none required", rf_addr, rf_wr_data);
        end else check("rf_wr", {rf_addr, rf_wr_data}, exp_wr_q.pop_front());
      end else check("rf_wr_data_hold", rf_wr_data, p_wdata);
      if (rf_rd_en) begin
        n_rd++;
        if (exp_rd_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rf_rd: strobe with addr=0x%0h, none required", rf_addr);
        end else check("rf_rd_addr", rf_addr, exp_rd_q.pop_front());
      end
      if (!rf_wr_en && !rf_rd_en) check("rf_addr_hold", rf_addr, p_addr);
      if (alu_en) begin
        n_alu++;
        gate_open = 1;
        if (exp_alu_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL alu_en: strobe with fun=0x%0h, none required", alu_fun);
        end else check("alu_fun", alu_fun, exp_alu_q.pop_front());
      end else check("alu_fun_hold", alu_fun, p_fun);
      if (tx_d_vld) begin
        n_tx++;
        tx_log.push_back(tx_p_data);
        check("tx_while_full", last_full, 0);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx: push of 0x%0h, none required", tx_p_data);
        end else check("tx_data", tx_p_data, exp_q.pop_front());
        if (exp_q.size() == 0) m_busy = 0;
      end else check("tx_data_hold", tx_p_data, p_txd);
      check("clk_gate", clk_gate_en, gate_open);
      if (alu_out_vld) gate_open = 0;
    end
    p_wr = rf_wr_en; p_rd = rf_rd_en; p_alu = alu_en; p_tx = tx_d_vld;
    p_addr = rf_addr; p_wdata = rf_wr_data; p_fun = alu_fun; p_txd = tx_p_data;
    last_full = fifo_full;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    model_byte(b);
    @(posedge clk); #1;
    rx_d_vld = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((exp_wr_q.size() + exp_rd_q.size() + exp_alu_q.size() + exp_q.size() != 0 || m_busy)
           && i < 300) begin
      @(posedge clk); i++;
    end
    check("idle_within_budget", (i < 300), 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_rf_wr_en", rf_wr_en, 0);
    check("rst_rf_rd_en", rf_rd_en, 0);
    check("rst_alu_en", alu_en, 0);
    check("rst_tx_d_vld", tx_d_vld, 0);
    check("rst_clk_gate", clk_gate_en, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_rf_wr_data", rf_wr_data, 0);
    check("rst_alu_fun", alu_fun, 0);
    check("rst_tx_p_data", tx_p_data, 0);
    check("rst_state_idle", dbg_state, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w0, r0, a0, t0, s0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state();

    // write AA,05,3C
    w0 = n_wr; t0 = n_tx;
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    wait_idle();
    check("wr_count", n_wr - w0, 1);
    check("wr_no_tx", n_tx - t0, 0);
    check("wr_mem5", rf_mem[5], 8'h3C);

    // write then read back address 2
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h5A);
    r0 = n_rd; t0 = n_tx;
    send_byte(8'hBB); send_byte(8'h02);
    wait_idle();
    check("rd_count", n_rd - r0, 1);
    check("rd_tx_count", n_tx - t0, 1);
    check("rd_tx_value", tx_log[tx_log.size()-1], 8'h5A);

    // ALU with operands: 0x0A + 0x03 = 0x000D
    alu_ret = 16'h000D;
    w0 = n_wr; a0 = n_alu; t0 = n_tx;
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h00);
    wait_idle();
    check("alu_wr_count", n_wr - w0, 2);
    check("alu_opa_mem", rf_mem[0], 8'h0A);
    check("alu_opb_mem", rf_mem[1], 8'h03);
    check("alu_en_count", n_alu - a0, 1);
    check("alu_tx_count", n_tx - t0, 2);
    check("alu_tx_lsb", tx_log[tx_log.size()-2], 8'h0D);
    check("alu_tx_msb", tx_log[tx_log.size()-1], 8'h00);
    check("alu_gate_low_after", clk_gate_en, 0);

    // backpressure: FIFO full for 10 cycles while result is pending
    alu_ret = 16'h1234;
    @(posedge clk); #1;
    fifo_full = 1'b1;
    t0 = n_tx;
    send_byte(8'hDD); send_byte(8'h02);
    repeat (10) @(posedge clk); #1;
    check("bp_no_tx_while_full", n_tx - t0, 0);
    fifo_full = 1'b0;
    wait_idle();
    check("bp_tx_count", n_tx - t0, 2);
    check("bp_tx_lsb", tx_log[tx_log.size()-2], 8'h34);
    check("bp_tx_msb", tx_log[tx_log.size()-1], 8'h12);

    // invalid byte in IDLE
    s0 = n_wr + n_rd + n_alu + n_tx;
    send_byte(8'h7E);
    repeat (3) @(posedge clk);
    check("invalid_no_strobe", n_wr + n_rd + n_alu + n_tx - s0, 0);
    check("invalid_stays_idle", dbg_state, 0);

    // byte dropped during ALU_WAIT, then a normal write
    alu_delay = 20;
    alu_ret = 16'hBEEF;
    w0 = n_wr; t0 = n_tx;
    send_byte(8'hDD); send_byte(8'h05);
    send_byte(8'hAA);
    wait_idle();
    check("drop_no_wr", n_wr - w0, 0);
    check("drop_tx_lsb", tx_log[tx_log.size()-2], 8'hEF);
    check("drop_tx_msb", tx_log[tx_log.size()-1], 8'hBE);
    alu_delay = 3;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
    wait_idle();
    check("after_drop_wr_count", n_wr - w0, 1);
    check("after_drop_mem1", rf_mem[1], 8'hFF);

    // reset mid-command
    w0 = n_wr; r0 = n_rd; t0 = n_tx;
    send_byte(8'hAA); send_byte(8'h04);
    do_reset();
    check_reset_state();
    send_byte(8'hBB); send_byte(8'h04);
    wait_idle();
    check("midrst_no_wr", n_wr - w0, 0);
    check("midrst_rd_count", n_rd - r0, 1);
    check("midrst_tx_value", tx_log[tx_log.size()-1], 8'h00);
    check("midrst_tx_count", n_tx - t0, 1);

    check("end_wr_q_empty", exp_wr_q.size(), 0);
    check("end_rd_q_empty", exp_rd_q.size(), 0);
    check("end_alu_q_empty", exp_alu_q.size(), 0);
    check("end_tx_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_sched.md
SYS_CTRL_SCHED -- requirements
Module: sys_ctrl_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the UART byte and register-file data.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the width of the register-file address.
REQ-003 REF_CLK  in  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 RST  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 RX_P_DATA  in  8  SHALL carry the received UART byte.
REQ-006 RX_D_VLD  in  1  SHALL qualify RX_P_DATA with a one-cycle pulse per byte.
REQ-007 RF_RD_DATA  in  8, RF_RD_VLD  in  1  SHALL carry the register-file read result and its valid strobe.
REQ-008 ALU_OUT  in  16, ALU_OUT_VLD  in  1  SHALL carry the ALU result and its valid strobe.
REQ-009 FIFO_FULL  in  1  SHALL indicate that the TX FIFO cannot accept a byte.
REQ-010 RF_WR_EN, RF_RD_EN  out  1 each  SHALL be the register-file write and read strobes.
REQ-011 RF_ADDR  out  4, RF_WR_DATA  out  8  SHALL be the register-file address and write data.
REQ-012 ALU_EN  out  1, ALU_FUN  out  4  SHALL be the ALU enable and function code.
REQ-013 CLK_GATE_EN  out  1  SHALL enable the ALU clock gate.
REQ-014 TX_P_DATA  out  8, TX_D_VLD  out  1  SHALL be the byte pushed to the TX FIFO and its one-cycle push strobe.

Function
REQ-015 The block SHALL implement these states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_RD, OPA, OPB, FUN, ALU_WAIT, TX_LSB, TX_MSB; all outputs SHALL be registered.
REQ-016 In IDLE, an accepted byte SHALL select the next state:
  - 0xAA -> WR_ADDR
  - 0xBB -> RD_ADDR
  - 0xCC -> OPA
  - 0xDD -> FUN
  - any other byte -> discarded; state stays IDLE.
REQ-017 WR_ADDR: on RX_D_VLD, SHALL latch byte[3:0] as the address, then go to WR_DATA.
REQ-018 WR_DATA: on RX_D_VLD, SHALL drive RF_WR_EN=1 for exactly one cycle with the latched address and byte, then return to IDLE.
REQ-019 RD_ADDR: on RX_D_VLD, SHALL drive RF_RD_EN=1 for exactly one cycle with RF_ADDR=byte[3:0], then go to RD_WAIT.
REQ-020 RD_WAIT: on RF_RD_VLD, SHALL latch RF_RD_DATA and go to TX_RD.
REQ-021 OPA: on RX_D_VLD, SHALL write the byte to address 0x0 (one-cycle RF_WR_EN), then go to OPB.
REQ-022 OPB: on RX_D_VLD, SHALL write the byte to address 0x1 (one-cycle RF_WR_EN), then go to FUN.
REQ-023 FUN: on RX_D_VLD, SHALL drive ALU_EN=1 for one cycle with ALU_FUN=byte[3:0], set CLK_GATE_EN=1, then go to ALU_WAIT.
REQ-024 CLK_GATE_EN SHALL stay high from the FUN acceptance through the cycle ALU_OUT_VLD is seen, and be low otherwise.
REQ-025 ALU_WAIT: on ALU_OUT_VLD, SHALL latch ALU_OUT and go to TX_LSB.
REQ-026 TX_RD, TX_LSB, TX_MSB: while FIFO_FULL=1, SHALL hold state with TX_D_VLD=0; when FIFO_FULL=0, SHALL push one byte with one-cycle TX_D_VLD=1.
  - TX_RD pushes the read data, then returns to IDLE.
  - TX_LSB pushes ALU_OUT[7:0], then goes to TX_MSB.
  - TX_MSB pushes ALU_OUT[15:8], then returns to IDLE.
REQ-027 RX_D_VLD arriving in RD_WAIT, ALU_WAIT or any TX state SHALL be ignored and the byte dropped; state is unchanged.
REQ-028 RF_WR_EN, RF_RD_EN, ALU_EN and TX_D_VLD SHALL be mutually exclusive in any cycle and never high for two consecutive cycles.
REQ-029 RF_ADDR, RF_WR_DATA, ALU_FUN and TX_P_DATA SHALL hold their last value when their strobe is low.

Reset
REQ-030 With RST=1 at a rising edge:
  - state SHALL go to IDLE
  - all strobes and CLK_GATE_EN SHALL be 0
  - RF_ADDR, RF_WR_DATA, ALU_FUN and TX_P_DATA SHALL be 0
  - latched operands and results SHALL be cleared.
REQ-031 Reset mid-command (any state) SHALL abandon the command with no further strobe; the next byte after RST=0 SHALL be decoded as a command.

Verification
REQ-032 Write: bytes AA,05,3C -> exactly one RF_WR_EN cycle with RF_ADDR=5, RF_WR_DATA=0x3C; TX_D_VLD never asserts.
REQ-033 Read: AA,02,5A then BB,02; model returns 0x5A two cycles after RF_RD_EN -> RF_RD_EN once with RF_ADDR=2; then one TX push of 0x5A.
REQ-034 ALU with operands: CC,0A,03,00; ALU model returns 0x000D -> writes addr0=0x0A and addr1=0x03, ALU_EN with ALU_FUN=0; TX pushes 0x0D then 0x00; CLK_GATE_EN low afterward.
REQ-035 Backpressure: DD,02 with ALU_OUT=0x1234 and FIFO_FULL=1 for 10 cycles -> no TX_D_VLD while full; then 0x34 and 0x12 pushed in order, one push each.
REQ-036 Invalid or dropped bytes:
  - byte 0x7E in IDLE -> no strobe, stays IDLE
  - byte during ALU_WAIT -> dropped; the following AA,01,FF write completes normally.
REQ-037 Reset mid-command: assert RST after AA,04 -> no RF_WR_EN occurs; then BB,04 produces RF_RD_EN with RF_ADDR=4.
